// File: rtl/exu_dispatch_if.sv
// exu_dispatch_if: fetch-to-dispatch handshake plus the dispatch-to-handler broadcast.
// Ports: ifu_vld/ifu_rdy/ifu_inst/ifu_pc (fetch side), flush, lsu_busy,
//        exu_inst/exu_pc, misc/alu/bju/lsu_sel, ill_vld/ill_pc, retire (handler side).
// slave = dispatch stage, master = surrounding pipeline.
interface exu_dispatch_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              ifu_vld;
  logic              ifu_rdy;
  logic [INST_W-1:0] ifu_inst;
  logic [PC_W-1:0]   ifu_pc;
  logic              flush;
  logic              lsu_busy;
  logic [INST_W-1:0] exu_inst;
  logic [PC_W-1:0]   exu_pc;
  logic              misc_sel;
  logic              alu_sel;
  logic              bju_sel;
  logic              lsu_sel;
  logic              ill_vld;
  logic [PC_W-1:0]   ill_pc;
  logic              retire;

  modport master (
    output ifu_vld, ifu_inst, ifu_pc, flush, lsu_busy,
    input  ifu_rdy, exu_inst, exu_pc, misc_sel, alu_sel, bju_sel, lsu_sel,
           ill_vld, ill_pc, retire
  );

  modport slave (
    input  ifu_vld, ifu_inst, ifu_pc, flush, lsu_busy,
    output ifu_rdy, exu_inst, exu_pc, misc_sel, alu_sel, bju_sel, lsu_sel,
           ill_vld, ill_pc, retire
  );
endinterface

// File: rtl/exu_dispatch.sv
// exu_dispatch: holds the oldest fetched instruction, decodes it to one-hot handler
// selects and retires it (or flags it illegal) once the selected handler accepts.
// Ports: clk, rst (async, active-high), bus (exu_dispatch_if.slave).
// Option: define EXU_DISPATCH_SKID_EN to add a second (skid) entry behind the head,
// which makes ifu_rdy a pure register output.
module exu_dispatch #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  exu_dispatch_if.slave  bus
);
  // Purpose: single/two-entry dispatch head with opcode decode and illegal detection.
  // Latency: accepted in cycle N, presented to handlers and retired in N+1 unless stalled.
  // Backpressure: only lsu_busy stalls the head; ifu_rdy drops when no entry can be freed.

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } entry_t;

  typedef enum logic [2:0] {
    CLS_ILL,
    CLS_MISC,
    CLS_ALU,
    CLS_BJU,
    CLS_LSU
  } cls_e;

  logic   head_vld;
  entry_t head_q;
  entry_t ifu_in;
  cls_e   head_cls;
  logic   illegal;
  logic   advance;
  logic   ifu_rdy_int;
  logic   ifu_xfer;

  assign ifu_in = '{inst: bus.ifu_inst, pc: bus.ifu_pc};

  // All legal opcodes end in 2'b11, so a full 7-bit match also covers the
  // compressed-encoding rejection.
  always_comb begin
    head_cls = CLS_ILL;
    case (head_q.inst[6:0])
      7'b0110111, 7'b0010111:             head_cls = CLS_MISC;
      7'b0010011, 7'b0110011:             head_cls = CLS_ALU;
      7'b1101111, 7'b1100111, 7'b1100011: head_cls = CLS_BJU;
      7'b0000011, 7'b0100011:             head_cls = CLS_LSU;
      default:                            head_cls = CLS_ILL;
    endcase
  end

  assign illegal = (head_cls == CLS_ILL);
  // Illegal heads never wait on a handler; only an lsu head can be held.
  assign advance = head_vld && !((head_cls == CLS_LSU) && bus.lsu_busy);

  assign bus.misc_sel = head_vld && (head_cls == CLS_MISC);
  assign bus.alu_sel  = head_vld && (head_cls == CLS_ALU);
  assign bus.bju_sel  = head_vld && (head_cls == CLS_BJU);
  assign bus.lsu_sel  = head_vld && (head_cls == CLS_LSU);
  assign bus.exu_inst = head_q.inst;
  assign bus.exu_pc   = head_q.pc;
  assign bus.ill_pc   = head_q.pc;
  // flush never suppresses these: an advancing head completes even when flushed.
  assign bus.retire   = advance && !illegal;
  assign bus.ill_vld  = advance && illegal;

  assign ifu_xfer    = bus.ifu_vld && ifu_rdy_int;
  assign bus.ifu_rdy = ifu_rdy_int;

`ifdef EXU_DISPATCH_SKID_EN
  logic   skid_vld;
  entry_t skid_q;

  // Registered ready: room exists whenever the skid slot is empty.
  assign ifu_rdy_int = !skid_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_vld <= 1'b0;
      head_q   <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
    end else if (bus.flush) begin
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (advance || !head_vld) begin
      // Head frees up: the skid entry is older than anything on the IFU port,
      // and an occupied skid already holds ifu_rdy low so no transfer collides.
      if (skid_vld) begin
        head_q   <= skid_q;
        head_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (ifu_xfer) begin
        head_q   <= ifu_in;
        head_vld <= 1'b1;
      end else begin
        head_vld <= 1'b0;
      end
    end else if (ifu_xfer) begin
      skid_q   <= ifu_in;
      skid_vld <= 1'b1;
    end
  end
`else
  // Combinational from lsu_busy so a retiring head can be replaced in the same cycle.
  assign ifu_rdy_int = !head_vld || advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_vld <= 1'b0;
      head_q   <= '0;
    end else if (bus.flush) begin
      head_vld <= 1'b0;
    end else if (ifu_xfer) begin
      head_q   <= ifu_in;
      head_vld <= 1'b1;
    end else if (advance) begin
      head_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_exu_dispatch.sv
// tb_exu_dispatch: directed scenarios plus random traffic against a queue-based model.
// The model keeps in-flight instructions in a queue (depth 1, or 2 with
// EXU_DISPATCH_SKID_EN) and derives every expected output from its front entry.
module tb_exu_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  exu_dispatch_if #(.PC_W(32), .INST_W(32)) bus ();

  exu_dispatch #(.PC_W(32), .INST_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef EXU_DISPATCH_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_ADDI  = 32'h00108093;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Handler classes: 0 illegal, 1 misc, 2 alu, 3 bju, 4 lsu.
  logic [6:0] op_tab  [9] = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
  int         cls_tab [9] = '{1, 1, 2, 2, 3, 3, 3, 4, 4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [31:0] inst);
    int c = 0;
    for (int i = 0; i < 9; i++)
      if (inst[6:0] == op_tab[i]) c = cls_tab[i];
    return c;
  endfunction

  // Called at posedge+1: drive inputs, check at negedge, update model, return at next posedge+1.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic fl, input logic busy);
    logic [3:0] exp_sel;
    logic       adv;
    logic       ill;
    logic       rdy;
    int         c;
    ent_t       e;
    bus.ifu_vld  = v;
    bus.ifu_inst = inst;
    bus.ifu_pc   = pc;
    bus.flush    = fl;
    bus.lsu_busy = busy;
    @(negedge clk);
    exp_sel = '0;
    adv     = 1'b0;
    ill     = 1'b0;
    if (q.size() > 0) begin
      c   = cls_of(q[0].inst);
      ill = (c == 0);
      if (!ill) exp_sel[c-1] = 1'b1;
      adv = !((c == 4) && busy);
      check("exu_inst", bus.exu_inst, q[0].inst);
      check("exu_pc", bus.exu_pc, q[0].pc);
      if (ill) check("ill_pc", bus.ill_pc, q[0].pc);
    end
    if (DEPTH == 2) rdy = (q.size() < 2);
    else            rdy = (q.size() == 0) || adv;
    check("sel{lsu,bju,alu,misc}",
          {28'd0, bus.lsu_sel, bus.bju_sel, bus.alu_sel, bus.misc_sel}, {28'd0, exp_sel});
    check("retire", {31'd0, bus.retire}, {31'd0, adv && !ill});
    check("ill_vld", {31'd0, bus.ill_vld}, {31'd0, adv && ill});
    check("ifu_rdy", {31'd0, bus.ifu_rdy}, {31'd0, rdy});
    if (adv) void'(q.pop_front());
    if (fl) begin
      q.delete();
    end else if (v && rdy) begin
      e.inst = inst;
      e.pc   = pc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sel"}, {28'd0, bus.lsu_sel, bus.bju_sel, bus.alu_sel, bus.misc_sel}, 32'd0);
    check({tag, ".retire"}, {31'd0, bus.retire}, 32'd0);
    check({tag, ".ill_vld"}, {31'd0, bus.ill_vld}, 32'd0);
    check({tag, ".exu_inst"}, bus.exu_inst, 32'd0);
    check({tag, ".exu_pc"}, bus.exu_pc, 32'd0);
    check({tag, ".ill_pc"}, bus.ill_pc, 32'd0);
  endtask

  function automatic logic [31:0] rand_inst();
    int k = $urandom_range(0, 11);
    case (k)
      0:       return I_LUI;
      1:       return I_ADDI;
      2:       return I_ADD;
      3:       return I_BEQ;
      4:       return I_JAL;
      5:       return I_JALR;
      6:       return I_AUIPC;
      7:       return I_LW;
      8:       return I_SW;
      9:       return I_BAD;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc;
    bus.ifu_vld  = 1'b0;
    bus.ifu_inst = '0;
    bus.ifu_pc   = '0;
    bus.flush    = 1'b0;
    bus.lsu_busy = 1'b0;
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back misc then alu.
    step(1'b1, I_LUI, 32'h100, 1'b0, 1'b0);
    step(1'b1, I_ADDI, 32'h104, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // LW stalled for three cycles, with a follow-on ADD offered.
    step(1'b1, I_LW, 32'h110, 1'b0, 1'b0);
    step(1'b1, I_ADD, 32'h114, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Illegal instruction followed immediately by a legal one.
    step(1'b1, I_BAD, 32'h200, 1'b0, 1'b0);
    step(1'b1, I_ADDI, 32'h204, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Advancing BEQ with flush: BEQ retires, the same-cycle fetch is dropped.
    step(1'b1, I_BEQ, 32'h204, 1'b0, 1'b0);
    step(1'b1, I_ADD, 32'h208, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush while LW is stalled (skid holds ADD when present).
    step(1'b1, I_LW, 32'h300, 1'b0, 1'b0);
    step(1'b1, I_ADD, 32'h304, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset pulsed mid lsu stall.
    step(1'b1, I_LW, 32'h400, 1'b0, 1'b0);
    step(1'b1, I_SW, 32'h404, 1'b0, 1'b1);
    bus.ifu_vld  = 1'b0;
    bus.lsu_busy = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, I_LUI, 32'h500, 1'b0, 1'b0);
    step(1'b1, I_LW, 32'h504, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Random traffic.
    pc = 32'h1000;
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 7, rand_inst(), pc,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
      pc = pc + 32'd4;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exu_dispatch.md
# exu_dispatch

Single-entry (optionally two-entry) dispatch stage between the instruction fetch unit and the execute-unit handlers.
- Accepts fetched instructions on a valid/ready handshake and holds the oldest one at the head.
- Decodes its opcode into one-hot handler selects (misc, alu, bju, lsu) and drives instruction/PC to all handlers.
- Retires it when the selected handler can accept it.
- Absorbs branch flushes and flags illegal opcodes.

## Interface
Parameters:
- PC_W, 32, width of program counter (matches `RV_PC_SIZE`)
- INST_W, 32, instruction width (fixed RV32I encoding)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_vld  in  1  fetched instruction valid
- ifu_rdy  out  1  dispatch can accept this cycle
- ifu_inst  in  INST_W  fetched instruction
- ifu_pc  in  PC_W  PC of fetched instruction
- flush  in  1  discard all younger-than-head work (from bju redirect)
- lsu_busy  in  1  lsu cannot complete the head instruction this cycle
- exu_inst  out  INST_W  head instruction, broadcast to all handlers
- exu_pc  out  PC_W  head PC
- misc_sel / alu_sel / bju_sel / lsu_sel  out  1 each  one-hot handler select
- ill_vld  out  1  one-cycle pulse, head instruction illegal
- ill_pc  out  PC_W  PC of illegal instruction, valid with ill_vld
- retire  out  1  one-cycle pulse, head instruction consumed

## Operation
- Head register: head_vld, head_inst, head_pc. Loaded on an IFU transfer (ifu_vld && ifu_rdy) when empty or advancing.
- Decode on head_inst. Requires inst[1:0]==2'b11, else illegal.
  - LUI 0110111, AUIPC 0010111 -> misc
  - OP-IMM 0010011, OP 0110011 -> alu
  - JAL 1101111, JALR 1100111, BRANCH 1100011 -> bju
  - LOAD 0000011, STORE 0100011 -> lsu
  - anything else -> illegal
- Selects: exactly the decoded *_sel is high while head_vld; all low when head empty or illegal.
- advance = head_vld && !(lsu_sel && lsu_busy). Illegal heads advance unconditionally.
- retire = advance && !illegal; ill_vld = advance && illegal; ill_pc = head_pc.
- Handler selects stay high for the whole lsu stall; misc/alu/bju never stall.
- Flush behaviour:
  - If the head advances this cycle, it still retires.
  - Any non-advancing head is dropped without retire.
  - Any buffered entry and any IFU transfer in the same cycle are dropped.
  - State is empty the next cycle.

## Timing
- Reset: head_vld=0, skid valid=0, all *_sel=0, retire=0, ill_vld=0, exu_inst=0, exu_pc=0, ill_pc=0. ifu_rdy=1 once reset deasserts.
- Latency: instruction accepted in cycle N appears on exu_*/sel in cycle N+1; retires in N+1 if not stalled.
- Throughput: one instruction per cycle with no stall.
- Without skid: ifu_rdy = !head_vld || advance. This is a combinational path from lsu_busy, and flush does not gate ifu_rdy.
- Reset asserted mid-stall: state clears immediately (async); no retire or ill_vld pulse is generated.

## Configuration
- EXU_DISPATCH_SKID_EN defined:
  - Adds a second (skid) entry behind the head; ifu_rdy = !skid_vld, a pure register output.
  - On advance, skid moves to head; an IFU transfer fills head if head would be empty, else skid.
  - With head stalled and skid empty, one further instruction is accepted, then ifu_rdy drops.
  - Latency unchanged; flush clears both entries.
- Undefined: single head register only; ifu_rdy combinational as in Timing.

## Test plan
- Back-to-back LUI (0x123450B7, pc 0x100) then ADDI (0x00108093, pc 0x104) -> misc_sel cycle 1, alu_sel cycle 2, retire high both cycles, ifu_rdy constantly 1.
- LW at head with lsu_busy high 3 cycles -> lsu_sel held 4 cycles, retire single pulse in 4th cycle; without skid ifu_rdy=0 for 3 cycles, with skid ifu_rdy=1 one more cycle then 0.
- Instruction 0xFFFFFFFF at pc 0x200 -> no sel high, ill_vld pulse with ill_pc=0x200, retire=0, next instruction dispatched following cycle.
- BEQ at head advancing plus flush, IFU presenting pc 0x208 same cycle -> retire=1 for BEQ, 0x208 dropped, next cycle head_vld=0, all sel=0.
- Flush while LW stalled (lsu_busy=1) with skid holding ADD -> no retire, both entries cleared, ifu_rdy=1 next cycle.
- rst pulsed mid lsu stall -> all outputs 0 asynchronously, no retire/ill_vld pulse, normal dispatch after release.
